reg_file_wr_arbiter: RTL and testbench
======================================

Name:
reg_file_wr_arbiter

Overview:
- Owns the single write port of the rv32i `reg_file`.
- After reset, sequences a full clear of all registers to zero.
- Then shares the write port between two write-back requesters (req0 = ALU write-back, req1 = load/mem write-back) using round-robin with valid/ready handshakes.
- Drives `reg_file` `i_WA`/`i_WD`/`i_WE` directly from registered outputs.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width; equals clog2(NREG).
- DW, 32, data width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req0_valid  in  1  requester 0 has a write pending.
- i_req0_addr  in  AW  requester 0 destination register.
- i_req0_data  in  DW  requester 0 write data.
- o_req0_ready  out  1  requester 0 write accepted this cycle.
- i_req1_valid  in  1  requester 1 has a write pending.
- i_req1_addr  in  AW  requester 1 destination register.
- i_req1_data  in  DW  requester 1 write data.
- o_req1_ready  out  1  requester 1 write accepted this cycle.
- o_WA  out  AW  to `reg_file` `i_WA`.
- o_WD  out  DW  to `reg_file` `i_WD`.
- o_WE  out  1  to `reg_file` `i_WE`.
- o_init_done  out  1  high once the clear sequence has completed.
- o_grant  out  1  index of the last accepted requester.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-low.
- **Reset** (i_rst_n low at an edge):
  - o_WE=0, o_WA=0, o_WD=0, o_init_done=0, o_grant=0.
  - Round-robin priority pointer = req0; state=CLEAR; clear counter=0.
  - Readies are low while in reset.
- **FSM states:** CLEAR, RUN.
- **CLEAR:**
  - Each edge registers o_WE=1, o_WA=cnt, o_WD=0, then cnt+1.
  - The first clear write appears one cycle after reset release.
  - Addresses 0..NREG-1 are written on NREG consecutive cycles; x0 is included.
  - On the edge issuing address NREG-1: state<=RUN and o_init_done<=1. o_init_done is therefore high in the cycle the last clear write is presented.
  - Both readies are held 0 throughout CLEAR.
- **RUN:**
  - Readies are combinational from state, valids and the priority pointer.
  - Only one valid: that requester's ready=1.
  - Both valid: ready goes to the pointer's requester only.
  - Neither valid: both readies=0.
  - Both readies are never high together.
- **Transfer:**
  - A transfer occurs when valid&&ready.
  - At the next edge: o_WE<=1 (0 if addr==0), o_WA<=addr, o_WD<=data, o_grant<=index, pointer<=other requester.
  - Write latency is 1 cycle from acceptance to o_WE at the `reg_file`.
- **x0 writes:** accepted (ready=1, consumes the grant, toggles the pointer) but o_WE=0; o_WA and o_WD still update.
- **No transfer in RUN:** o_WE<=0; o_WA, o_WD, o_grant and the pointer hold.
- **Requester obligation:** addr and data stay stable while valid && !ready; valid is not withdrawn before acceptance.
- **Throughput:** one write per cycle sustained; continuous contention alternates strictly 0,1,0,1.
- **Reset mid-operation:** in either state, reset aborts immediately. The pending write is dropped, the clear restarts from address 0 and o_init_done returns to 0.
- No buffering: a requester that is not granted waits; nothing is queued internally.

Test Plan:
- **Reset clear sequence:** hold i_rst_n=0 for 3 cycles, then release -> 32 consecutive cycles with o_WE=1, o_WA=0..31, o_WD=0. o_init_done rises with o_WA=31. Both readies stay 0 until o_init_done=1. Then o_WE=0.
- **Single requester:** after init, req0 valid with addr=5, data=0xDEADBEEF for one cycle -> o_req0_ready=1 that cycle. Next cycle: o_WE=1, o_WA=5, o_WD=0xDEADBEEF, o_grant=0.
- **Contention:** req0 (addr=1, 0x11) and req1 (addr=2, 0x22) both held valid for 6 cycles -> accepts alternate 0,1,0,1,0,1. o_WA sequence is 1,2,1,2,1,2 with matching data. Readies are never both 1.
- **x0 drop:** req1 valid with addr=0, data=0xFF -> o_req1_ready=1. Next cycle o_WE=0, o_WA=0, o_grant=1. A following lone req0 write is accepted immediately.
- **Back-pressure:** pointer=req1; both valid (req0 addr=3 data=0x33, req1 addr=4 data=0x44) -> req1 accepted first. req0 stalls with stable inputs and is accepted the next cycle. Outputs show o_WA=4 then o_WA=3.
- **Reset mid-operation:** assert i_rst_n=0 during CLEAR at o_WA=10 and again in RUN during contention -> next edge o_WE=0, o_init_done=0, readies 0. After release, the clear restarts at o_WA=0.

Source files
------------

// File: rtl/reg_file_wr_arbiter.sv
`default_nettype none
// reg_file_wr_arbiter: owns the reg_file write port, clears every register after
// reset, then round-robins writes from two valid/ready write-back requesters.
module reg_file_wr_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0_valid,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_data,
  output logic          o_req0_ready,
  input  logic          i_req1_valid,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_data,
  output logic          o_req1_ready,
  output logic [AW-1:0] o_WA,
  output logic [DW-1:0] o_WD,
  output logic          o_WE,
  output logic          o_init_done,
  output logic          o_grant
);

  localparam logic [0:0]    ST_CLEAR  = 1'b0;
  localparam logic [0:0]    ST_RUN    = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          ptr;
  logic          accept0;
  logic          accept1;

  // Readies are gated by reset so nothing is accepted in a cycle that will be aborted.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (i_rst_n && (state == ST_RUN)) begin
      o_req0_ready = i_req0_valid && (!i_req1_valid || (ptr == 1'b0));
      o_req1_ready = i_req1_valid && (!i_req0_valid || (ptr == 1'b1));
    end
  end

  assign accept0 = i_req0_valid && o_req0_ready;
  assign accept1 = i_req1_valid && o_req1_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      ptr         <= 1'b0;
      o_WE        <= 1'b0;
      o_WA        <= '0;
      o_WD        <= '0;
      o_init_done <= 1'b0;
      o_grant     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          o_WE    <= 1'b1;
          o_WA    <= clr_cnt;
          o_WD    <= '0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state       <= ST_RUN;
            o_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          // x0 writes still consume the grant but never assert the enable.
          if (accept0) begin
            o_WE    <= (i_req0_addr != '0);
            o_WA    <= i_req0_addr;
            o_WD    <= i_req0_data;
            o_grant <= 1'b0;
            ptr     <= 1'b1;
          end else if (accept1) begin
            o_WE    <= (i_req1_addr != '0);
            o_WA    <= i_req1_addr;
            o_WD    <= i_req1_data;
            o_grant <= 1'b1;
            ptr     <= 1'b0;
          end else begin
            o_WE <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wr_arbiter.sv
`default_nettype none
// Directed bench: a reference model pushes expected write-port values per cycle,
// popped and compared one edge later.
module tb_reg_file_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        rdy0, rdy1;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we, init_done, grant;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        grant;
    logic        init;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic       m_run;
  logic [5:0] m_cnt;
  logic       m_ptr;
  exp_t       m_out;

  always #5 clk = ~clk;

  reg_file_wr_arbiter #(.NREG(32), .AW(5), .DW(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .i_req0_addr(a0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_addr(a1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .o_WA(wa), .o_WD(wd), .o_WE(we), .o_init_done(init_done), .o_grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic r, input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                     input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
    logic e0, e1;
    exp_t got;
    rst_n = r; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
    #1;
    e0 = r && m_run && iv0 && (!iv1 || !m_ptr);
    e1 = r && m_run && iv1 && (!iv0 ||  m_ptr);
    chk("ready0", {31'b0, rdy0}, {31'b0, e0});
    chk("ready1", {31'b0, rdy1}, {31'b0, e1});
    chk("ready_excl", {31'b0, rdy0 & rdy1}, 32'd0);
    if (!r) begin
      m_out = '0; m_run = 1'b0; m_cnt = '0; m_ptr = 1'b0;
    end else if (!m_run) begin
      m_out.we = 1'b1; m_out.wa = m_cnt[4:0]; m_out.wd = '0;
      if (m_cnt == 6'd31) begin m_run = 1'b1; m_out.init = 1'b1; end
      m_cnt = m_cnt + 1'b1;
    end else if (e0) begin
      m_out.we = (ia0 != 0); m_out.wa = ia0; m_out.wd = id0; m_out.grant = 1'b0; m_ptr = 1'b1;
    end else if (e1) begin
      m_out.we = (ia1 != 0); m_out.wa = ia1; m_out.wd = id1; m_out.grant = 1'b1; m_ptr = 1'b0;
    end else begin
      m_out.we = 1'b0;
    end
    sb.push_back(m_out);
    @(posedge clk);
    @(negedge clk);
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk("we",    {31'b0, we},        {31'b0, got.we});
      chk("wa",    {27'b0, wa},        {27'b0, got.wa});
      chk("wd",    wd,                 got.wd);
      chk("grant", {31'b0, grant},     {31'b0, got.grant});
      chk("init",  {31'b0, init_done}, {31'b0, got.init});
    end
  endtask

  task automatic idle(input logic r);
    cyc(r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    m_run = 1'b0; m_cnt = '0; m_ptr = 1'b0; m_out = '0;
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    @(negedge clk);

    // reset then full clear
    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_init", {31'b0, init_done}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      idle(1'b1);
      chk("clr_addr", {27'b0, wa}, i);
    end
    chk("clr_done_init", {31'b0, init_done}, 32'd1);
    idle(1'b1);
    chk("post_clr_we", {31'b0, we}, 32'd0);

    // single requester
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("single_wa", {27'b0, wa}, 32'd5);
    chk("single_wd", wd, 32'hDEADBEEF);
    idle(1'b1);
    // lone req1 so the pointer returns to req0 before contention
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77);

    // contention: 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      chk("cont_wa", {27'b0, wa}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end

    // x0 drop then lone req0
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
    chk("x0_we", {31'b0, we}, 32'd0);
    chk("x0_grant", {31'b0, grant}, 32'd1);
    cyc(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);

    // back-pressure with pointer at req1
    cyc(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    chk("bp_first", {27'b0, wa}, 32'd4);
    cyc(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    chk("bp_second", {27'b0, wa}, 32'd3);
    idle(1'b1);

    // reset in CLEAR at address 10
    idle(1'b0);
    for (int i = 0; i < 11; i++) idle(1'b1);
    chk("mid_clr_wa", {27'b0, wa}, 32'd10);
    idle(1'b0);
    chk("mid_clr_rst_we", {31'b0, we}, 32'd0);
    idle(1'b1);
    chk("clr_restart", {27'b0, wa}, 32'd0);
    for (int i = 0; i < 31; i++) idle(1'b1);

    // reset in RUN during contention
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    cyc(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    chk("run_rst_init", {31'b0, init_done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("run_rst_clr", {27'b0, wa}, i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
